// File: rtl/spi_slave_responder.sv
// -----------------------------------------------------------------------------
// spi_slave_responder
//
// SPI responder (slave) for SPI mode 3 (CPOL=1, CPHA=1), MSB first,
// DATA_W-bit words, active-low chip select. SCLK, MOSI and CS are
// oversampled on sys_clk and never used as clocks.
//
// Received words leave on a valid/ready stream (rx_*). Transmit words enter
// on a valid/ready stream (tx_*) through a one-deep holding register.
//
// Handshake rule (both streams): a word moves on every sys_clk rising edge
// where valid and ready are both 1. A producer keeps valid and data stable
// until that edge. rx_valid_o is held until accepted. tx_ready_o means the
// holding register is empty.
//
// Parameters:
//   DATA_W       bits per SPI word (2 or more)
//   SYNC_STAGES  synchronizer depth on spi_clk_i/spi_mosi_i/spi_cs_i (>= 2)
//   FILL_WORD    word shifted out when no transmit word is available
//
// Ports:
//   sys_clk        system clock, all logic on its rising edge
//   sys_rst        synchronous active-high reset
//   spi_clk_i      SCLK from the initiator, idles high
//   spi_mosi_i     initiator-to-responder data
//   spi_cs_i       chip select, active low
//   spi_miso_o     responder-to-initiator data
//   spi_miso_oe_o  MISO output enable, 1 while the frame is active
//   rx_data_o      last received word
//   rx_valid_o     rx_data_o valid, held until accepted
//   rx_ready_i     consumer accepts rx_data_o
//   tx_data_i      next word to transmit
//   tx_valid_i     tx_data_i valid
//   tx_ready_o     holding register empty
//   tx_underrun_o  one-cycle pulse when FILL_WORD is loaded
//   rx_overrun_o   sticky overrun flag
//
// Optional feature, macro SPI_SLAVE_RX_OVERRUN_EN:
//   defined   - rx_overrun_o is set when a word completes while rx_valid_o=1
//               and rx_ready_i=0, and clears on the next accepted word.
//   undefined - rx_overrun_o is tied 0.
//   An unaccepted word is overwritten by the newer one in both builds.
//
// SCLK timing: every SCLK phase must last at least SYNC_STAGES+2 sys_clk
// cycles.
// -----------------------------------------------------------------------------
module spi_slave_responder #(
    parameter int                DATA_W      = 8,
    parameter int                SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] FILL_WORD   = '0
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              spi_clk_i,
    input  logic              spi_mosi_i,
    input  logic              spi_cs_i,
    output logic              spi_miso_o,
    output logic              spi_miso_oe_o,
    output logic [DATA_W-1:0] rx_data_o,
    output logic              rx_valid_o,
    input  logic              rx_ready_i,
    input  logic [DATA_W-1:0] tx_data_i,
    input  logic              tx_valid_i,
    output logic              tx_ready_o,
    output logic              tx_underrun_o,
    output logic              rx_overrun_o
);

    localparam int CNT_W = $clog2(DATA_W);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    // Synchronizers and edge detection
    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   sclk_q;
    logic                   sclk_s;
    logic                   cs_s;
    logic                   mosi_s;
    logic                   sclk_rise;
    logic                   sclk_fall;

    // Frame state
    state_t                 state_q;
    logic [CNT_W-1:0]       bit_cnt_q;
    logic [DATA_W-2:0]      rx_shift_q;   // bits received so far, MSB first
    logic [DATA_W-2:0]      tx_shift_q;   // bits still to present after MSB
    logic [DATA_W-1:0]      hold_q;
    logic                   hold_full_q;

    // Registered outputs
    logic                   miso_q;
    logic                   miso_oe_q;
    logic [DATA_W-1:0]      rx_data_q;
    logic                   rx_valid_q;
    logic                   underrun_q;

    // Next-word selection
    logic                   tx_accept;
    logic                   word_done;
    logic                   load_now;
    logic [DATA_W-1:0]      load_word_d;
    logic                   load_underrun_d;
    logic [DATA_W-1:0]      rx_word_d;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sclk_sync_q <= '1;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_q      <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_clk_i};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_i};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi_i};
            sclk_q      <= sclk_s;
        end
    end

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_q;
    assign sclk_fall = ~sclk_s & sclk_q;

    assign tx_accept = tx_valid_i & ~hold_full_q;
    assign rx_word_d = {rx_shift_q, mosi_s};

    // The rise that delivers the last bit of a word completes it and
    // immediately loads the next word into the shifter.
    assign word_done = (state_q == ST_ACTIVE) & ~cs_s & sclk_rise &
                       (bit_cnt_q == CNT_W'(DATA_W - 1));
    assign load_now  = ((state_q == ST_IDLE) & ~cs_s) | word_done;

    // A word arriving on the tx stream in the same cycle as a load with an
    // empty holding register goes straight into the shifter.
    always_comb begin
        load_word_d     = FILL_WORD;
        load_underrun_d = 1'b1;
        if (hold_full_q) begin
            load_word_d     = hold_q;
            load_underrun_d = 1'b0;
        end else if (tx_accept) begin
            load_word_d     = tx_data_i;
            load_underrun_d = 1'b0;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            rx_shift_q  <= '0;
            tx_shift_q  <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            miso_q      <= 1'b0;
            miso_oe_q   <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            underrun_q <= 1'b0;

            // Holding register: a load empties it (or bypasses it); otherwise
            // an accepted word fills it.
            if (load_now) begin
                if (hold_full_q) begin
                    hold_full_q <= 1'b0;
                end
            end else if (tx_accept) begin
                hold_q      <= tx_data_i;
                hold_full_q <= 1'b1;
            end

            // A completing word wins over a same-cycle accept.
            if (word_done) begin
                rx_data_q  <= rx_word_d;
                rx_valid_q <= 1'b1;
            end else if (rx_valid_q && rx_ready_i) begin
                rx_valid_q <= 1'b0;
            end

            if (load_now) begin
                miso_q     <= load_word_d[DATA_W-1];
                tx_shift_q <= load_word_d[DATA_W-2:0];
                bit_cnt_q  <= '0;
                underrun_q <= load_underrun_d;
            end

            case (state_q)
                ST_IDLE: begin
                    if (!cs_s) begin
                        state_q   <= ST_ACTIVE;
                        miso_oe_q <= 1'b1;
                    end else begin
                        miso_q    <= 1'b0;
                        miso_oe_q <= 1'b0;
                    end
                end
                ST_ACTIVE: begin
                    if (cs_s) begin
                        // Partial word and any loaded tx word are dropped.
                        state_q   <= ST_IDLE;
                        miso_q    <= 1'b0;
                        miso_oe_q <= 1'b0;
                        bit_cnt_q <= '0;
                    end else if (sclk_rise && !word_done) begin
                        rx_shift_q <= rx_word_d[DATA_W-2:0];
                        bit_cnt_q  <= bit_cnt_q + CNT_W'(1);
                    end else if (sclk_fall && (bit_cnt_q != '0)) begin
                        // The first fall of a word leaves the MSB in place.
                        miso_q     <= tx_shift_q[DATA_W-2];
                        tx_shift_q <= tx_shift_q << 1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef SPI_SLAVE_RX_OVERRUN_EN
    logic overrun_q;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            overrun_q <= 1'b0;
        end else if (word_done && rx_valid_q && !rx_ready_i) begin
            overrun_q <= 1'b1;
        end else if (rx_valid_q && rx_ready_i) begin
            overrun_q <= 1'b0;
        end
    end

    assign rx_overrun_o = overrun_q;
`else
    assign rx_overrun_o = 1'b0;
`endif

    assign spi_miso_o    = miso_q;
    assign spi_miso_oe_o = miso_oe_q;
    assign rx_data_o     = rx_data_q;
    assign rx_valid_o    = rx_valid_q;
    assign tx_ready_o    = ~hold_full_q;
    assign tx_underrun_o = underrun_q;

endmodule

// File: tb/tb_spi_slave_responder.sv
// -----------------------------------------------------------------------------
// tb_spi_slave_responder
//
// Directed bench for spi_slave_responder (DATA_W=8, SYNC_STAGES=2,
// FILL_WORD=8'h00). An SPI mode 3 initiator is modelled by tasks; MISO is
// sampled at each SCLK rising edge the initiator produces.
// -----------------------------------------------------------------------------
module tb_spi_slave_responder;

    localparam int W    = 8;
    localparam int HALF = 8;   // sys_clk cycles per SCLK phase

    logic         sys_clk = 1'b0;
    logic         sys_rst;
    logic         spi_clk_i;
    logic         spi_mosi_i;
    logic         spi_cs_i;
    logic         spi_miso_o;
    logic         spi_miso_oe_o;
    logic [W-1:0] rx_data_o;
    logic         rx_valid_o;
    logic         rx_ready_i;
    logic [W-1:0] tx_data_i;
    logic         tx_valid_i;
    logic         tx_ready_o;
    logic         tx_underrun_o;
    logic         rx_overrun_o;

    int           total = 0;
    int           bad   = 0;
    int           under_cnt = 0;
    logic [W-1:0] rx_got[$];

`ifdef SPI_SLAVE_RX_OVERRUN_EN
    localparam logic OVR_EXP = 1'b1;
`else
    localparam logic OVR_EXP = 1'b0;
`endif

    spi_slave_responder #(
        .DATA_W      (W),
        .SYNC_STAGES (2),
        .FILL_WORD   (8'h00)
    ) dut (
        .sys_clk       (sys_clk),
        .sys_rst       (sys_rst),
        .spi_clk_i     (spi_clk_i),
        .spi_mosi_i    (spi_mosi_i),
        .spi_cs_i      (spi_cs_i),
        .spi_miso_o    (spi_miso_o),
        .spi_miso_oe_o (spi_miso_oe_o),
        .rx_data_o     (rx_data_o),
        .rx_valid_o    (rx_valid_o),
        .rx_ready_i    (rx_ready_i),
        .tx_data_i     (tx_data_i),
        .tx_valid_i    (tx_valid_i),
        .tx_ready_o    (tx_ready_o),
        .tx_underrun_o (tx_underrun_o),
        .rx_overrun_o  (rx_overrun_o)
    );

    // Clock and watchdog
    always #5 sys_clk = ~sys_clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Collect accepted rx words and underrun pulses away from the active edge.
    always @(negedge sys_clk) begin
        if (!sys_rst) begin
            if (rx_valid_o && rx_ready_i) rx_got.push_back(rx_data_o);
            if (tx_underrun_o) under_cnt++;
        end
    end

    // Driver tasks
    task automatic cyc(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic spi_bits(input logic [W-1:0] mosi_w, input int nbits,
                            output logic [W-1:0] miso_w);
        miso_w = '0;
        for (int i = 0; i < nbits; i++) begin
            spi_clk_i  = 1'b0;
            spi_mosi_i = mosi_w[W-1-i];
            cyc(HALF);
            spi_clk_i         = 1'b1;
            miso_w[W-1-i]     = spi_miso_o;
            cyc(HALF);
        end
    endtask

    task automatic cs_low();
        spi_cs_i = 1'b0;
        cyc(HALF);
    endtask

    task automatic cs_high();
        spi_cs_i   = 1'b1;
        spi_mosi_i = 1'b0;
        cyc(2 * HALF);
    endtask

    task automatic tx_push(input logic [W-1:0] d);
        logic ok;
        ok         = 1'b0;
        tx_data_i  = d;
        tx_valid_i = 1'b1;
        for (int k = 0; k < 600 && !ok; k++) begin
            if (tx_ready_o) ok = 1'b1;
            cyc(1);
        end
        tx_valid_i = 1'b0;
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL tx_push_timeout word=%h accepted=%0b required=1", d, ok);
        end
    endtask

    // Test tasks
    task automatic test_reset();
        sys_rst = 1'b1;
        cyc(3);
        total++;
        if ({spi_miso_o, spi_miso_oe_o, rx_data_o, rx_valid_o, tx_ready_o,
             tx_underrun_o, rx_overrun_o} !== {1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_outputs miso=%b oe=%b rx=%h rv=%b trdy=%b und=%b ovr=%b required 0 0 00 0 1 0 0",
                     spi_miso_o, spi_miso_oe_o, rx_data_o, rx_valid_o, tx_ready_o,
                     tx_underrun_o, rx_overrun_o);
        end
        sys_rst = 1'b0;
        cyc(HALF);
    endtask

    task automatic test_basic();
        logic [W-1:0] m;
        int u0;
        u0 = under_cnt;
        rx_got.delete();
        tx_push(8'hA5);
        cs_low();
        total++;
        if (spi_miso_oe_o !== 1'b1) begin
            bad++; $display("FAIL basic_oe got=%b required=1", spi_miso_oe_o);
        end
        total++;
        if (under_cnt - u0 !== 0) begin
            bad++; $display("FAIL basic_entry_underrun got=%0d required=0", under_cnt - u0);
        end
        spi_bits(8'h3C, 8, m);
        cs_high();
        total++;
        if (m !== 8'hA5) begin
            bad++; $display("FAIL basic_miso got=%h required=a5", m);
        end
        total++;
        if (rx_got.size() !== 1) begin
            bad++; $display("FAIL basic_rx_count got=%0d required=1", rx_got.size());
        end else if (rx_got[0] !== 8'h3C) begin
            bad++; $display("FAIL basic_rx_data got=%h required=3c", rx_got[0]);
        end
        // The word-boundary load after the last bit finds no held word.
        total++;
        if (under_cnt - u0 !== 1) begin
            bad++; $display("FAIL basic_trailing_underrun got=%0d required=1", under_cnt - u0);
        end
        total++;
        if (spi_miso_oe_o !== 1'b0) begin
            bad++; $display("FAIL basic_oe_idle got=%b required=0", spi_miso_oe_o);
        end
    endtask

    task automatic test_underrun();
        logic [W-1:0] m;
        int u0;
        u0 = under_cnt;
        rx_got.delete();
        cs_low();
        total++;
        if (under_cnt - u0 !== 1) begin
            bad++; $display("FAIL underrun_entry got=%0d required=1", under_cnt - u0);
        end
        spi_bits(8'hFF, 8, m);
        cs_high();
        total++;
        if (m !== 8'h00) begin
            bad++; $display("FAIL underrun_miso got=%h required=00", m);
        end
        total++;
        if (rx_got.size() !== 1 || rx_got[0] !== 8'hFF) begin
            bad++; $display("FAIL underrun_rx count=%0d data=%h required 1 ff",
                            rx_got.size(), (rx_got.size() > 0) ? rx_got[0] : 8'hxx);
        end
        total++;
        if (under_cnt - u0 !== 2) begin
            bad++; $display("FAIL underrun_total got=%0d required=2", under_cnt - u0);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] m0, m1, m2;
        int u0;
        u0 = under_cnt;
        rx_got.delete();
        tx_push(8'hC3);
        fork
            begin
                tx_push(8'h96);
                tx_push(8'h7E);
            end
            begin
                cs_low();
                spi_bits(8'h01, 8, m0);
                spi_bits(8'h02, 8, m1);
                total++;
                if (under_cnt - u0 !== 0) begin
                    bad++; $display("FAIL b2b_mid_underrun got=%0d required=0", under_cnt - u0);
                end
                spi_bits(8'h03, 8, m2);
                cs_high();
            end
        join
        total++;
        if ({m0, m1, m2} !== {8'hC3, 8'h96, 8'h7E}) begin
            bad++; $display("FAIL b2b_miso got=%h %h %h required=c3 96 7e", m0, m1, m2);
        end
        total++;
        if (rx_got.size() !== 3) begin
            bad++; $display("FAIL b2b_rx_count got=%0d required=3", rx_got.size());
        end else if ({rx_got[0], rx_got[1], rx_got[2]} !== {8'h01, 8'h02, 8'h03}) begin
            bad++; $display("FAIL b2b_rx_data got=%h %h %h required=01 02 03",
                            rx_got[0], rx_got[1], rx_got[2]);
        end
        total++;
        if (under_cnt - u0 !== 1) begin
            bad++; $display("FAIL b2b_end_underrun got=%0d required=1", under_cnt - u0);
        end
    endtask

    task automatic test_abort();
        logic [W-1:0] m;
        rx_got.delete();
        cs_low();
        spi_bits(8'hFF, 5, m);
        cs_high();
        total++;
        if (rx_got.size() !== 0 || rx_valid_o !== 1'b0) begin
            bad++; $display("FAIL abort_no_rx count=%0d rv=%b required 0 0", rx_got.size(), rx_valid_o);
        end
        tx_push(8'h5A);
        cs_low();
        spi_bits(8'h81, 8, m);
        cs_high();
        total++;
        if (rx_got.size() !== 1 || rx_got[0] !== 8'h81) begin
            bad++; $display("FAIL abort_next_rx count=%0d data=%h required 1 81",
                            rx_got.size(), (rx_got.size() > 0) ? rx_got[0] : 8'hxx);
        end
        total++;
        if (m !== 8'h5A) begin
            bad++; $display("FAIL abort_next_miso got=%h required=5a", m);
        end
    endtask

    task automatic test_overrun();
        logic [W-1:0] m;
        rx_got.delete();
        rx_ready_i = 1'b0;
        cs_low();
        spi_bits(8'h11, 8, m);
        total++;
        if (rx_valid_o !== 1'b1 || rx_data_o !== 8'h11 || rx_overrun_o !== 1'b0) begin
            bad++; $display("FAIL overrun_first rv=%b rx=%h ovr=%b required 1 11 0",
                            rx_valid_o, rx_data_o, rx_overrun_o);
        end
        spi_bits(8'h22, 8, m);
        cs_high();
        total++;
        if (rx_valid_o !== 1'b1 || rx_data_o !== 8'h22) begin
            bad++; $display("FAIL overrun_overwrite rv=%b rx=%h required 1 22", rx_valid_o, rx_data_o);
        end
        total++;
        if (rx_overrun_o !== OVR_EXP) begin
            bad++; $display("FAIL overrun_flag got=%b required=%b", rx_overrun_o, OVR_EXP);
        end
        rx_ready_i = 1'b1;
        cyc(1);
        total++;
        if (rx_valid_o !== 1'b0 || rx_overrun_o !== 1'b0) begin
            bad++; $display("FAIL overrun_accept rv=%b ovr=%b required 0 0", rx_valid_o, rx_overrun_o);
        end
        cyc(2);
        total++;
        if (rx_got.size() !== 1 || rx_got[0] !== 8'h22) begin
            bad++; $display("FAIL overrun_accepted_word count=%0d data=%h required 1 22",
                            rx_got.size(), (rx_got.size() > 0) ? rx_got[0] : 8'hxx);
        end
    endtask

    task automatic test_reset_mid_word();
        logic [W-1:0] m;
        tx_push(8'hC3);
        cs_low();
        tx_push(8'h3C);   // sits in the holding register
        spi_bits(8'hFF, 3, m);
        sys_rst = 1'b1;
        cyc(1);
        total++;
        if ({spi_miso_o, spi_miso_oe_o, rx_data_o, rx_valid_o, tx_ready_o,
             tx_underrun_o, rx_overrun_o} !== {1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL midreset_outputs miso=%b oe=%b rx=%h rv=%b trdy=%b und=%b ovr=%b required 0 0 00 0 1 0 0",
                     spi_miso_o, spi_miso_oe_o, rx_data_o, rx_valid_o, tx_ready_o,
                     tx_underrun_o, rx_overrun_o);
        end
        spi_cs_i   = 1'b1;
        spi_clk_i  = 1'b1;
        spi_mosi_i = 1'b0;
        cyc(2 * HALF);
        sys_rst = 1'b0;
        cyc(HALF);
        rx_got.delete();
        tx_push(8'hE7);
        cs_low();
        spi_bits(8'h5A, 8, m);
        cs_high();
        total++;
        if (rx_got.size() !== 1 || rx_got[0] !== 8'h5A) begin
            bad++; $display("FAIL midreset_next_rx count=%0d data=%h required 1 5a",
                            rx_got.size(), (rx_got.size() > 0) ? rx_got[0] : 8'hxx);
        end
        total++;
        if (m !== 8'hE7) begin
            bad++; $display("FAIL midreset_next_miso got=%h required=e7", m);
        end
    endtask

    initial begin
        sys_rst    = 1'b1;
        spi_clk_i  = 1'b1;
        spi_mosi_i = 1'b0;
        spi_cs_i   = 1'b1;
        rx_ready_i = 1'b1;
        tx_data_i  = '0;
        tx_valid_i = 1'b0;

        test_reset();
        test_basic();
        test_underrun();
        test_back_to_back();
        test_abort();
        test_overrun();
        test_reset_mid_word();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
